// File: rtl/fft_twiddle_sequencer_pkg.sv
// ============================================================================
// Module : fft_pkg
// Brief  : Shared constants, types and helpers for the FFT twiddle sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int TW_W      = 16;
  localparam int IDX_W     = FFT_LOG2N;
  localparam int STAGE_W   = 3;
  localparam int TW_UNITY  = 1000;

  typedef logic signed [TW_W-1:0]  tw_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [IDX_W-2:0]        bfly_t;
  typedef logic [STAGE_W-1:0]      stage_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam tw_t TW_MIN = {1'b1, {(TW_W-1){1'b0}}};
  localparam tw_t TW_MAX = {1'b0, {(TW_W-1){1'b1}}};

  // Two's complement negation that maps the most negative code to the most positive.
  function automatic tw_t sat_neg(input tw_t x);
    if (x == TW_MIN) return TW_MAX;
    return -x;
  endfunction

endpackage : fft_pkg

`default_nettype wire

// File: rtl/fft_twiddle_sequencer_if.sv
// ============================================================================
// Module : fft_twiddle_sequencer_if
// Brief  : Butterfly descriptor valid/ready bus between sequencer and datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fft_twiddle_sequencer_if;
  import fft_pkg::*;

  logic   out_valid_o;
  logic   out_ready_i;
  tw_t    tw_re_o;
  tw_t    tw_im_o;
  idx_t   addr_top_o;
  idx_t   addr_bot_o;
  stage_t stage_o;

  modport master (
    output out_valid_o, tw_re_o, tw_im_o, addr_top_o, addr_bot_o, stage_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, tw_re_o, tw_im_o, addr_top_o, addr_bot_o, stage_o,
    output out_ready_i
  );

endinterface : fft_twiddle_sequencer_if

`default_nettype wire

// File: rtl/fft_twiddle_sequencer_addr_gen.sv
// ============================================================================
// Module : fft_bfly_addr_gen
// Brief  : Combinational radix-2 DIT map (stage, bfly) -> (top, bot, twiddle k).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_bfly_addr_gen
  import fft_pkg::*;
(
  input  wire stage_t s_i,
  input  wire bfly_t  j_i,
  output idx_t        addr_top_o,
  output idx_t        addr_bot_o,
  output bfly_t       k_o
);

  bfly_t w_mask;
  bfly_t w_pos;
  idx_t  w_grp;
  idx_t  w_span;

  // At the last stage the span no longer fits in bfly_t; 0 - 1 still yields the full mask.
  assign w_mask     = (bfly_t'(1) << s_i) - bfly_t'(1);
  assign w_pos      = j_i & w_mask;
  assign w_grp      = {1'b0, j_i} >> s_i;
  assign w_span     = idx_t'(1) << s_i;
  assign addr_top_o = (w_grp << (s_i + stage_t'(1))) | {1'b0, w_pos};
  assign addr_bot_o = addr_top_o + w_span;
  assign k_o        = w_pos << (stage_t'(FFT_LOG2N - 1) - s_i);

endmodule : fft_bfly_addr_gen

`default_nettype wire

// File: rtl/fft_twiddle_sequencer.sv
// ============================================================================
// Module : fft_twiddle_sequencer
// Brief  : Walks every stage/butterfly of an N-point radix-2 DIT FFT and issues
//          twiddle + address descriptors over a valid/ready bus.
//          Optional macro FFT_TWIDDLE_INVERSE_EN adds inv_i (conjugate twiddles).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_twiddle_sequencer
  import fft_pkg::*;
(
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire tw_t [FFT_N/2-1:0] real_tw_i,
  input  wire tw_t [FFT_N/2-1:0] imag_tw_i,
  input  wire                 start_i,
  input  wire                 abort_i,
`ifdef FFT_TWIDDLE_INVERSE_EN
  input  wire                 inv_i,
`endif
  fft_twiddle_sequencer_if.master bus,
  output logic                busy_o,
  output logic                done_o
);

  localparam stage_t LAST_STAGE = stage_t'(FFT_LOG2N - 1);
  localparam bfly_t  LAST_BFLY  = '1;

  seq_state_t state_q;
  stage_t     stage_q, w_nx_stage;
  bfly_t      bfly_q, w_nx_bfly;
  logic       valid_q, busy_q, done_q;
  tw_t        tw_re_q, tw_im_q;
  idx_t       top_q, bot_q;

  idx_t       w_top, w_bot;
  bfly_t      w_k;
  tw_t        w_re, w_im;
  logic       w_last, w_xfer;

  assign w_last = (stage_q == LAST_STAGE) && (bfly_q == LAST_BFLY);
  assign w_xfer = valid_q && bus.out_ready_i;

  // Index of the descriptor that loads on the next edge; (0,0) when starting from IDLE.
  always_comb begin
    w_nx_stage = '0;
    w_nx_bfly  = '0;
    if (state_q == RUN) begin
      w_nx_bfly  = bfly_q + bfly_t'(1);
      w_nx_stage = (bfly_q == LAST_BFLY) ? stage_q + stage_t'(1) : stage_q;
    end
  end

  fft_bfly_addr_gen u_addr_gen (
    .s_i        (w_nx_stage),
    .j_i        (w_nx_bfly),
    .addr_top_o (w_top),
    .addr_bot_o (w_bot),
    .k_o        (w_k)
  );

  assign w_re = real_tw_i[w_k];

`ifdef FFT_TWIDDLE_INVERSE_EN
  logic inv_q;
  logic w_inv;

  // The first descriptor loads on the same edge that latches inv_i.
  assign w_inv = (state_q == IDLE) ? inv_i : inv_q;
  assign w_im  = w_inv ? sat_neg(imag_tw_i[w_k]) : imag_tw_i[w_k];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            inv_q <= 1'b0;
    else if (state_q == IDLE && start_i)   inv_q <= inv_i;
  end
`else
  assign w_im = imag_tw_i[w_k];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tw_re_q <= '0;
      tw_im_q <= '0;
      top_q   <= '0;
      bot_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RUN;
            stage_q <= w_nx_stage;
            bfly_q  <= w_nx_bfly;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            tw_re_q <= w_re;
            tw_im_q <= w_im;
            top_q   <= w_top;
            bot_q   <= w_bot;
          end
        end
        RUN: begin
          if (abort_i || (w_xfer && w_last)) begin
            state_q <= abort_i ? IDLE : DONE;
            done_q  <= !abort_i;
            stage_q <= '0;
            bfly_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            tw_re_q <= '0;
            tw_im_q <= '0;
            top_q   <= '0;
            bot_q   <= '0;
          end else if (w_xfer) begin
            stage_q <= w_nx_stage;
            bfly_q  <= w_nx_bfly;
            tw_re_q <= w_re;
            tw_im_q <= w_im;
            top_q   <= w_top;
            bot_q   <= w_bot;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid_o = valid_q;
  assign bus.tw_re_o     = tw_re_q;
  assign bus.tw_im_o     = tw_im_q;
  assign bus.addr_top_o  = top_q;
  assign bus.addr_bot_o  = bot_q;
  assign bus.stage_o     = stage_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule : fft_twiddle_sequencer

`default_nettype wire

// File: tb/tb_fft_twiddle_sequencer.sv
// ============================================================================
// Module : tb_fft_twiddle_sequencer
// Brief  : Scoreboard bench: stimulus pushes expected descriptors, a negedge
//          monitor pops and compares on every accepted beat.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_twiddle_sequencer;
  import fft_pkg::*;

  typedef struct {
    int idx;
    int stg;
    int top;
    int bot;
    int re;
    int im;
  } desc_t;

  // round(1000*cos(2*pi*k/32)) and round(-1000*sin(2*pi*k/32)), k = 0..15
  int RE_T[16] = '{1000, 981, 924, 831, 707, 556, 383, 195,
                   0, -195, -383, -556, -707, -831, -924, -981};
  int IM_T[16] = '{0, -195, -383, -556, -707, -831, -924, -981,
                   -1000, -981, -924, -831, -707, -556, -383, -195};

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic inv_drv;
  logic busy;
  logic done;
  tw_t [FFT_N/2-1:0] real_tw;
  tw_t [FFT_N/2-1:0] imag_tw;

  fft_twiddle_sequencer_if bus ();

  fft_twiddle_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .real_tw_i (real_tw),
    .imag_tw_i (imag_tw),
    .start_i   (start),
    .abort_i   (abort),
`ifdef FFT_TWIDDLE_INVERSE_EN
    .inv_i     (inv_drv),
`endif
    .bus       (bus.master),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  desc_t sb[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  int    cur_inv  = 0;
  logic  idle_chk = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           post;          // 1: after last transfer, 2: after abort
  logic         prev_stall;
  logic [45:0]  snap;
  logic [45:0]  cur;
  desc_t        e;

  always @(negedge clk) begin
    cur = {bus.out_valid_o, bus.tw_re_o, bus.tw_im_o,
           bus.addr_top_o, bus.addr_bot_o, bus.stage_o};
    if (!rst_n) begin
      post       = 0;
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (post == 1) begin
        chk("done_pulse", done, 1);
        chk("valid_after_last", bus.out_valid_o, 0);
        chk("busy_after_last", busy, 0);
        chk("beats_left", sb.size(), 0);
      end else if (post == 2) begin
        chk("valid_after_abort", bus.out_valid_o, 0);
        chk("busy_after_abort", busy, 0);
        chk("done_after_abort", done, 0);
        sb.delete();
      end else if (done) begin
        chk("unexpected_done", done, 0);
      end
      post = 0;

      if (prev_stall) chk("stall_stable", cur, snap);

      if (idle_chk) begin
        chk("idle_outputs", cur, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end

      if (bus.out_valid_o && abort) begin
        post = 2;
      end else if (bus.out_valid_o && bus.out_ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("stage", int'(bus.stage_o), e.stg);
          chk("addr_top", int'(bus.addr_top_o), e.top);
          chk("addr_bot", int'(bus.addr_bot_o), e.bot);
          chk("tw_re", int'(bus.tw_re_o), e.re);
          chk("tw_im", int'(bus.tw_im_o), e.im);
          if (e.idx < 16) begin
            chk("s0_tw_re_unity", int'(bus.tw_re_o), 1000);
            chk("s0_tw_im_zero", int'(bus.tw_im_o), 0);
          end
          if (e.idx == 72) begin
            chk("s4_j8_top", int'(bus.addr_top_o), 8);
            chk("s4_j8_bot", int'(bus.addr_bot_o), 24);
            chk("s4_j8_re", int'(bus.tw_re_o), 0);
            chk("s4_j8_im", int'(bus.tw_im_o), (cur_inv != 0) ? 1000 : -1000);
          end
          if (e.idx == 79) post = 1;
        end
      end
      prev_stall = bus.out_valid_o && !bus.out_ready_i && !abort;
      snap       = cur;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_schedule(input int inv);
    desc_t d;
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 16; j++) begin
        int span, pos, k;
        span  = 1 << s;
        pos   = j % span;
        k     = pos * (32 / (2 * span));
        d.idx = s * 16 + j;
        d.stg = s;
        d.top = (j / span) * 2 * span + pos;
        d.bot = d.top + span;
        d.re  = RE_T[k];
        d.im  = (inv != 0) ? -IM_T[k] : IM_T[k];
        sb.push_back(d);
      end
    end
  endtask

  task automatic run_start(input int inv);
    push_schedule(inv);
    cur_inv = inv;
    inv_drv = (inv != 0);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int rnd);
    int base;
    base = done_cnt;
    for (int c = 0; c < 3000 && done_cnt == base; c++) begin
      @(posedge clk); #1;
      if (rnd != 0) bus.out_ready_i = 1'($urandom_range(0, 1));
    end
    bus.out_ready_i = 1'b1;
    if (done_cnt == base) begin
      $display("FAIL run_timeout: got no done_o expected done_o within 3000 cycles");
      $fatal(1, "timeout");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_front(input int idx);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0 && sb[0].idx == idx) hit = 1'b1;
    end
    if (!hit) begin
      $display("FAIL front_timeout: got no beat %0d expected beat %0d", idx, idx);
      $fatal(1, "timeout");
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    inv_drv         = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      real_tw[k] = tw_t'(RE_T[k]);
      imag_tw[k] = tw_t'(IM_T[k]);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    idle_chk = 1'b1;
    repeat (10) @(posedge clk);
    #1 idle_chk = 1'b0;

    // full rate
    run_start(0);
    wait_done(0);

    // random backpressure
    run_start(0);
    wait_done(1);

    // start during a run is ignored
    run_start(0);
    wait_front(20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0);

    // abort at stage 2, bfly 5 together with a ready beat, then restart
    run_start(0);
    wait_front(37);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_start(0);
    wait_done(0);

    // abort while idle does nothing
    abort = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    idle_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1 idle_chk = 1'b0;

`ifdef FFT_TWIDDLE_INVERSE_EN
    run_start(1);
    wait_done(0);
    run_start(0);
    wait_done(0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fft_twiddle_sequencer

`default_nettype wire
